// File: rtl/mips_mem_pkg.sv
// mips_mem_pkg: shared types and constants for the MIPS data-memory controller
package mips_mem_pkg;
    localparam int DMEM_ADDR_W = 7;
    localparam int WORD_W      = 32;
    typedef enum logic [1:0] {IDLE, RD_STROBE, RD_CAPTURE} dmem_state_t;
    typedef struct packed {
        logic cen;
        logic wen;
        logic oen;
    } strobe_t;
    localparam strobe_t STB_IDLE  = '{cen: 1'b1, wen: 1'b1, oen: 1'b1};
    localparam strobe_t STB_READ  = '{cen: 1'b0, wen: 1'b1, oen: 1'b0};
    localparam strobe_t STB_WRITE = '{cen: 1'b0, wen: 1'b0, oen: 1'b1};
endpackage

// File: rtl/dmem_ctrl_if.sv
// dmem_ctrl_if: core-side request/response bus of the data-memory controller
interface dmem_ctrl_if
    import mips_mem_pkg::*;
#(
    parameter int DATA_W = WORD_W
);
    logic              req_valid;
    logic              req_we;
    logic [31:0]       req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              req_ready;
    logic              resp_valid;
    logic [DATA_W-1:0] resp_rdata;
    logic              resp_err;
    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );
    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/dmem_wbuf.sv
// dmem_wbuf: single-entry posted write buffer with load/drain controls and hit compare
module dmem_wbuf
    import mips_mem_pkg::*;
#(
    parameter int ADDR_W = DMEM_ADDR_W,
    parameter int DATA_W = WORD_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic              i_drain,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_data,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic              o_valid,
    output logic              o_hit,
    output logic [ADDR_W-1:0] o_addr,
    output logic [DATA_W-1:0] o_data
);
    logic              r_valid;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_data;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_addr  <= '0;
            r_data  <= '0;
        end else begin
            r_valid <= i_load || (r_valid && !i_drain);
            if (i_load) begin
                r_addr <= i_addr;
                r_data <= i_data;
            end
        end
    end
    assign o_valid = r_valid;
    assign o_hit   = r_valid && (r_addr == i_rd_addr);
    assign o_addr  = r_addr;
    assign o_data  = r_data;
endmodule

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: word load/store controller for the 128-word synchronous data SRAM
module dmem_ctrl
    import mips_mem_pkg::*;
#(
    parameter int ADDR_W = DMEM_ADDR_W,
    parameter int DATA_W = WORD_W,
    parameter bit FWD_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    dmem_ctrl_if.slave        bus,
    output logic              wb_busy,
    output logic              CEN,
    output logic              WEN,
    output logic              OEN,
    output logic [ADDR_W-1:0] A,
    output logic [DATA_W-1:0] Data2Mem,
    input  logic [DATA_W-1:0] ReadDataMem
);
    dmem_state_t       r_state, w_next;
    strobe_t           r_stb, w_stb;
    logic [ADDR_W-1:0] r_a, w_a, w_waddr, w_wb_addr;
    logic [DATA_W-1:0] r_d2m, w_d2m, r_rdata, w_rdata, w_wb_data;
    logic              r_resp_valid, w_resp_valid, r_resp_err;
    logic              w_idle, w_hold, w_ready, w_acc, w_mis, w_st, w_ld;
    logic              w_hit, w_fwd, w_rd, w_drain, w_wb_valid, w_unused;
    assign w_waddr  = bus.req_addr[ADDR_W+1:2];
    assign w_unused = ^bus.req_addr[31:ADDR_W+2];
    always_comb begin
        w_idle       = r_state == IDLE;
        w_hold       = !FWD_EN && w_wb_valid && bus.req_valid && !bus.req_we;
        w_ready      = w_idle && !w_hold;
        w_acc        = bus.req_valid && w_ready;
        w_mis        = w_acc && (bus.req_addr[1:0] != 2'b00);
        w_st         = w_acc && !w_mis && bus.req_we;
        w_ld         = w_acc && !w_mis && !bus.req_we;
        w_fwd        = w_ld && FWD_EN && w_hit;
        w_rd         = w_ld && !w_fwd;
        // a read issue claims the SRAM port; the buffered store waits for a free IDLE cycle
        w_drain      = w_idle && w_wb_valid && !w_rd;
        w_next       = w_rd ? RD_STROBE : r_state == RD_STROBE ? RD_CAPTURE : IDLE;
        w_stb        = w_rd ? STB_READ : w_drain ? STB_WRITE : STB_IDLE;
        w_a          = w_rd ? w_waddr : w_drain ? w_wb_addr : r_a;
        w_d2m        = w_drain ? w_wb_data : r_d2m;
        w_resp_valid = w_mis || w_fwd || r_state == RD_CAPTURE;
        w_rdata      = w_fwd ? w_wb_data : r_state == RD_CAPTURE ? ReadDataMem : '0;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_stb        <= STB_IDLE;
            r_a          <= '0;
            r_d2m        <= '0;
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_rdata      <= '0;
        end else begin
            r_state      <= w_next;
            r_stb        <= w_stb;
            r_a          <= w_a;
            r_d2m        <= w_d2m;
            r_resp_valid <= w_resp_valid;
            r_resp_err   <= w_mis;
            r_rdata      <= w_rdata;
        end
    end
    dmem_wbuf #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_wbuf (
        .clk       (clk),
        .rst       (rst),
        .i_load    (w_st),
        .i_drain   (w_drain),
        .i_addr    (w_waddr),
        .i_data    (bus.req_wdata),
        .i_rd_addr (w_waddr),
        .o_valid   (w_wb_valid),
        .o_hit     (w_hit),
        .o_addr    (w_wb_addr),
        .o_data    (w_wb_data)
    );
    assign bus.req_ready  = w_ready;
    assign bus.resp_valid = r_resp_valid;
    assign bus.resp_err   = r_resp_err;
    assign bus.resp_rdata = r_rdata;
    assign wb_busy        = w_wb_valid;
    assign CEN            = r_stb.cen;
    assign WEN            = r_stb.wen;
    assign OEN            = r_stb.oen;
    assign A              = r_a;
    assign Data2Mem       = r_d2m;
endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl: directed checks of dmem_ctrl with forwarding on (dut0) and off (dut1)
module tb_dmem_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sel = 1'b0;
    logic        req_valid = 1'b0, req_we = 1'b0;
    logic [31:0] req_addr = '0, req_wdata = '0;
    int          n_chk = 0, n_err = 0;
    logic        cen0, wen0, oen0, busy0, cen1, wen1, oen1, busy1;
    logic [6:0]  a0, a1;
    logic [31:0] d0, d1, rd0, rd1;
    logic [31:0] mem0 [0:127];
    logic [31:0] mem1 [0:127];

    always #5 clk = ~clk;

    dmem_ctrl_if #(.DATA_W(32)) i0 ();
    dmem_ctrl_if #(.DATA_W(32)) i1 ();
    assign i0.req_valid = req_valid && !sel;
    assign i1.req_valid = req_valid && sel;
    assign i0.req_we    = req_we;
    assign i1.req_we    = req_we;
    assign i0.req_addr  = req_addr;
    assign i1.req_addr  = req_addr;
    assign i0.req_wdata = req_wdata;
    assign i1.req_wdata = req_wdata;

    dmem_ctrl #(.FWD_EN(1'b1)) dut0 (
        .clk(clk), .rst(rst), .bus(i0.slave), .wb_busy(busy0),
        .CEN(cen0), .WEN(wen0), .OEN(oen0), .A(a0), .Data2Mem(d0), .ReadDataMem(rd0)
    );
    dmem_ctrl #(.FWD_EN(1'b0)) dut1 (
        .clk(clk), .rst(rst), .bus(i1.slave), .wb_busy(busy1),
        .CEN(cen1), .WEN(wen1), .OEN(oen1), .A(a1), .Data2Mem(d1), .ReadDataMem(rd1)
    );

    always @(posedge clk) begin
        if (!cen0 && !wen0) mem0[a0] <= d0;
        if (!cen0 && !oen0) rd0 <= mem0[a0];
        if (!cen1 && !wen1) mem1[a1] <= d1;
        if (!cen1 && !oen1) rd1 <= mem1[a1];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic we, input logic [31:0] ad, input logic [31:0] wd);
        req_valid = v;
        req_we    = we;
        req_addr  = ad;
        req_wdata = wd;
        #1;
    endtask

    initial begin
        for (int i = 0; i < 128; i++) begin
            mem0[i] = '0;
            mem1[i] = '0;
        end
        mem0[3] = 32'hA5A5A5A5;
        step();
        step();
        rst = 1'b0;
        chk("rst_cen", cen0, 1);
        chk("rst_wen", wen0, 1);
        chk("rst_oen", oen0, 1);
        chk("rst_a", a0, 0);
        chk("rst_d2m", d0, 0);
        chk("rst_rv", i0.resp_valid, 0);
        chk("rst_busy", busy0, 0);
        drive(0, 0, 0, 0);
        chk("rst_ready", i0.req_ready, 1);

        // reset in the middle of a load
        drive(1, 0, 32'h10, 0);
        step();
        drive(0, 0, 0, 0);
        chk("mid_rd_oen", oen0, 0);
        chk("mid_rd_a", a0, 4);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_cen", cen0, 1);
        chk("mid_wen", wen0, 1);
        chk("mid_oen", oen0, 1);
        chk("mid_rv", i0.resp_valid, 0);
        chk("mid_ready", i0.req_ready, 1);
        chk("mid_busy", busy0, 0);
        step();
        chk("mid_rv2", i0.resp_valid, 0);

        // posted store then drain
        drive(1, 1, 32'h20, 32'hDEADBEEF);
        chk("st_ready", i0.req_ready, 1);
        step();
        drive(0, 0, 0, 0);
        chk("st_busy", busy0, 1);
        chk("st_cen0", cen0, 1);
        chk("st_rv", i0.resp_valid, 0);
        step();
        chk("dr_cen", cen0, 0);
        chk("dr_wen", wen0, 0);
        chk("dr_oen", oen0, 1);
        chk("dr_a", a0, 8);
        chk("dr_d2m", d0, 32'hDEADBEEF);
        chk("dr_busy", busy0, 0);
        step();
        chk("dr_cen_off", cen0, 1);

        // load forwarded from the write buffer
        drive(1, 1, 32'h40, 32'h1234);
        step();
        drive(1, 0, 32'h40, 0);
        chk("fw_ready", i0.req_ready, 1);
        step();
        drive(0, 0, 0, 0);
        chk("fw_rv", i0.resp_valid, 1);
        chk("fw_rdata", i0.resp_rdata, 32'h1234);
        chk("fw_err", i0.resp_err, 0);
        chk("fw_oen", oen0, 1);
        step();
        chk("fw_oen2", oen0, 1);
        chk("fw_rv2", i0.resp_valid, 0);

        // SRAM load of word 3
        drive(1, 0, 32'h0C, 0);
        step();
        drive(0, 0, 0, 0);
        chk("ld_cen", cen0, 0);
        chk("ld_oen", oen0, 0);
        chk("ld_wen", wen0, 1);
        chk("ld_a", a0, 3);
        chk("ld_ready1", i0.req_ready, 0);
        step();
        chk("ld_ready2", i0.req_ready, 0);
        chk("ld_oen2", oen0, 1);
        chk("ld_rv2", i0.resp_valid, 0);
        step();
        chk("ld_rv", i0.resp_valid, 1);
        chk("ld_rdata", i0.resp_rdata, 32'hA5A5A5A5);
        chk("ld_ready3", i0.req_ready, 1);

        // misaligned load and store
        drive(1, 0, 32'h13, 0);
        step();
        drive(1, 1, 32'h22, 32'h99);
        chk("mis_rv", i0.resp_valid, 1);
        chk("mis_err", i0.resp_err, 1);
        chk("mis_rdata", i0.resp_rdata, 0);
        chk("mis_cen", cen0, 1);
        step();
        drive(0, 0, 0, 0);
        chk("miss_rv", i0.resp_valid, 1);
        chk("miss_err", i0.resp_err, 1);
        chk("miss_busy", busy0, 0);
        step();
        chk("miss_cen", cen0, 1);
        chk("mis_rv_off", i0.resp_valid, 0);

        // back-to-back stores: drain and refill in one cycle
        drive(1, 1, 32'h0, 32'h11111111);
        chk("bb_ready0", i0.req_ready, 1);
        step();
        drive(1, 1, 32'h4, 32'h22222222);
        chk("bb_ready1", i0.req_ready, 1);
        chk("bb_busy1", busy0, 1);
        step();
        drive(0, 0, 0, 0);
        chk("bb_wen0", wen0, 0);
        chk("bb_a0", a0, 0);
        chk("bb_d0", d0, 32'h11111111);
        chk("bb_busy2", busy0, 1);
        step();
        chk("bb_wen1", wen0, 0);
        chk("bb_a1", a0, 1);
        chk("bb_d1", d0, 32'h22222222);
        chk("bb_busy3", busy0, 0);
        step();
        chk("bb_cen", cen0, 1);
        chk("bb_mem1", mem0[1], 32'h22222222);

        // miss load beats the drain; store waits for the read to finish
        drive(1, 1, 32'h8, 32'h77);
        step();
        drive(1, 0, 32'h0C, 0);
        step();
        drive(0, 0, 0, 0);
        chk("pr_oen", oen0, 0);
        chk("pr_a", a0, 3);
        chk("pr_busy", busy0, 1);
        step();
        chk("pr_wen_cap", wen0, 1);
        chk("pr_busy2", busy0, 1);
        step();
        chk("pr_rv", i0.resp_valid, 1);
        chk("pr_rdata", i0.resp_rdata, 32'hA5A5A5A5);
        chk("pr_wen_idle", wen0, 1);
        step();
        chk("pr_wen", wen0, 0);
        chk("pr_a2", a0, 2);
        chk("pr_d", d0, 32'h77);

        // forwarding disabled: drain first, then read from SRAM
        sel = 1'b1;
        drive(1, 1, 32'h40, 32'h1234);
        step();
        drive(1, 0, 32'h40, 0);
        chk("nf_ready0", i1.req_ready, 0);
        step();
        chk("nf_wen", wen1, 0);
        chk("nf_a", a1, 7'h10);
        chk("nf_d", d1, 32'h1234);
        chk("nf_ready1", i1.req_ready, 1);
        step();
        drive(0, 0, 0, 0);
        chk("nf_oen", oen1, 0);
        chk("nf_wen_rd", wen1, 1);
        chk("nf_a_rd", a1, 7'h10);
        step();
        chk("nf_rv_early", i1.resp_valid, 0);
        step();
        chk("nf_rv", i1.resp_valid, 1);
        chk("nf_rdata", i1.resp_rdata, 32'h1234);
        chk("nf_err", i1.resp_err, 0);
        sel = 1'b0;

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/dmem_ctrl.md
Name: dmem_ctrl

Overview:
- Data-memory controller directly downstream of the single-cycle MIPS datapath.
- Takes the core's word load/store requests (byte address, write data) and drives the 128-word synchronous data SRAM through active-low CEN/WEN/OEN, A[6:0] and Data2Mem.
- Returns load data through a valid pulse. A stalled core waits on req_ready.
- A single-entry posted write buffer takes stores in one cycle. A load that hits the buffered word is answered from the buffer.

Parameters:
- ADDR_W, 7, SRAM word-address width (A bits). Depth = 2^ADDR_W words.
- DATA_W, 32, data word width.
- FWD_EN, 1, 1 = loads that hit the write buffer are answered from it; 0 = write buffer drains before any load issues.

Ports:
- clk  in  1  single clock, all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  core presents a memory request this cycle.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address. Bits [ADDR_W+1:2] select the word; upper bits are ignored (wraps modulo depth).
- req_wdata  in  DATA_W  store data.
- req_ready  out  1  request accepted this cycle when req_valid & req_ready.
- resp_valid  out  1  one-cycle pulse: load data or error is valid.
- resp_rdata  out  DATA_W  load data (0 on error).
- resp_err  out  1  misaligned access, qualified by resp_valid.
- wb_busy  out  1  write buffer holds an undrained store.
- CEN  out  1  SRAM chip enable, active low. Always equals OEN & WEN.
- WEN  out  1  SRAM write enable, active low.
- OEN  out  1  SRAM output enable, active low.
- A  out  ADDR_W  SRAM word address.
- Data2Mem  out  DATA_W  SRAM write data.
- ReadDataMem  in  DATA_W  SRAM read data, valid the cycle after the read strobe.

Behaviour:
- Reset (rst=1 at an edge) takes effect from the next cycle, regardless of state:
  - state=IDLE; write buffer invalidated and its contents discarded (a reset mid-operation loses the pending store);
  - CEN=WEN=OEN=1; A=0; Data2Mem=0;
  - resp_valid=0, resp_rdata=0, resp_err=0, wb_busy=0.
- All SRAM-side outputs and resp_* are registered. req_ready is combinational: 1 iff state==IDLE.
- FSM states: IDLE, RD_STROBE, RD_CAPTURE.
- Misaligned request (req_addr[1:0]!=0), accepted at T:
  - no SRAM access and no buffer change;
  - at T+1: resp_valid=1, resp_err=1, rdata=0, for loads and stores alike.
- Store accepted at T:
  - written into the write buffer at the edge ending T; wb_busy=1 from T+1;
  - if the buffer was full, the old entry drains during that same edge, so the store is still accepted (drain and refill in one cycle);
  - no resp pulse.
- Drain: in IDLE, with the buffer valid and no SRAM read issued this cycle, the next cycle has CEN=0, WEN=0, OEN=1, A=buffer address, Data2Mem=buffer data, for exactly one cycle. The buffer clears at the same edge unless refilled.
- Load accepted at T, FWD_EN=1, buffer valid and word address equal: no SRAM access; state stays IDLE; T+1: resp_valid=1, rdata=buffer data.
- Load accepted at T, otherwise (miss, or FWD_EN=0):
  - FWD_EN=0 with buffer valid: the drain takes priority and req_ready is held 0 during that drain cycle.
  - T: state moves to RD_STROBE.
  - T+1: CEN=0, OEN=0, WEN=1, A=word address; state moves to RD_CAPTURE.
  - T+2: strobes deasserted; ReadDataMem sampled.
  - T+3: resp_valid=1, resp_rdata=sampled value; state back to IDLE.
  - Only one outstanding load. req_ready=0 from T+1 through T+2.
  - A buffered store does not drain while a read is in flight. It drains at the first IDLE cycle with no new read issue.
- Priority in IDLE: a miss-load read issue beats the buffer drain. A read never passes a buffered store to the same word, because FWD_EN=1 forwards and FWD_EN=0 drains first.
- Never drive WEN=0 and OEN=0 in the same cycle.
- Read and write strobes are never asserted in consecutive cycles for the same request.

Decomposition:
- Shared package mips_mem_pkg holds:
  - dmem_state_t enum {IDLE, RD_STROBE, RD_CAPTURE};
  - constants DMEM_ADDR_W=7 and WORD_W=32;
  - the SRAM strobe encoding constants (active-low idle/read/write triples).
- One sub-module, dmem_wbuf: the single-entry write buffer with valid/addr/data, load/drain controls, and a hit comparator output.

Test Plan:
- Reset mid-read: assert rst at T+2 of a load to 0x10 -> from the next cycle CEN=WEN=OEN=1, resp_valid stays 0, req_ready=1, wb_busy=0.
- Store 0xDEADBEEF to 0x20, idle -> wb_busy=1 next cycle; next cycle CEN=0, WEN=0, A=8, Data2Mem=0xDEADBEEF; then wb_busy=0.
- Store 0x1234 to 0x40, then load 0x40 the next cycle (FWD_EN=1) -> resp_valid one cycle later with 0x1234 and no SRAM strobe. With FWD_EN=0 -> drain first, then a read with A=0x10 returning the SRAM value.
- Load 0x0C with SRAM word 3 = 0xA5A5A5A5 -> T+1 CEN=OEN=0, A=3; T+3 resp_valid=1, rdata=0xA5A5A5A5; req_ready=0 at T+1 and T+2.
- Load 0x13 (misaligned) -> T+1 resp_valid=1, resp_err=1, rdata=0, no SRAM strobe.
- Back-to-back stores to 0x0 and 0x4 -> both accepted with req_ready=1; word 0 written to SRAM while word 1 fills the buffer; word 1 is written to SRAM on the following cycle.
